is_array_sequencer: RTL and testbench

IS_ARRAY_SEQUENCER -- requirements
Module: is_array_sequencer

---
 rtl/is_array_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_is_array_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/is_array_sequencer.sv
// -----------------------------------------------------------------------------
// is_array_sequencer
// Job sequencer for an input-stationary systolic array. A job loads
// ARRAY_WIDTH stationary input vectors, streams num_weights weight vectors
// through the array, drains the pipeline with zero weights and hands every
// psum vector out through a registered valid/ready port. Every array step is
// gated by downstream space (and, in RUN, by weight availability) so stalls on
// either side freeze the array without losing or duplicating results.
// A job-tag shift register tracks which array steps carry real weights.
// PIPE_LATENCY must be at least 2.
// -----------------------------------------------------------------------------
module is_array_sequencer #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int PIPE_LATENCY = ARRAY_HEIGHT + ARRAY_WIDTH,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [CNT_WIDTH-1:0]               num_weights,
    output logic                               busy,
    output logic                               done,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0] in_data,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] w_data,
    output logic                               array_input_en,
    output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0] array_input_in,
    output logic                               array_process_en,
    output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] array_weight_in,
    input  logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]  array_psum_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]  out_data
);

    // FSM encoding
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int                    IN_CNT_W = $clog2(ARRAY_WIDTH + 1);
    localparam logic [IN_CNT_W-1:0]   IN_LAST  = IN_CNT_W'(ARRAY_WIDTH - 1);
    localparam logic [IN_CNT_W-1:0]   IN_ONE   = IN_CNT_W'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    // State and bookkeeping registers
    logic [2:0]                          r_state;
    logic [CNT_WIDTH-1:0]                r_num_weights;
    logic [CNT_WIDTH-1:0]                r_w_cnt;
    logic [IN_CNT_W-1:0]                 r_in_cnt;
    logic [PIPE_LATENCY-1:0]             r_tags;
    logic                                r_out_valid;
    logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]  r_out_data;

    // Combinational control
    logic [2:0] w_state_nxt;
    logic       w_can_out;
    logic       w_run_step;
    logic       w_flush_step;
    logic       w_step;
    logic       w_new_tag;
    logic       w_tail;
    logic       w_tags_empty;
    logic       w_in_xfer;
    logic       w_last_in;
    logic       w_last_w;
    logic       w_start_ok;

    // Step qualification: an array step needs room at the output register;
    // in FLUSH there is no point stepping once no real weight is in flight.
    always_comb begin
        w_can_out    = !r_out_valid || out_ready;
        w_tags_empty = (r_tags == {PIPE_LATENCY{1'b0}});
        w_tail       = r_tags[PIPE_LATENCY-1];
        w_run_step   = 1'b0;
        w_flush_step = 1'b0;
        if (r_state == RUN) begin
            w_run_step = w_can_out && w_valid;
        end else if (r_state == FLUSH) begin
            w_flush_step = w_can_out && !w_tags_empty;
        end else begin
            w_run_step   = 1'b0;
            w_flush_step = 1'b0;
        end
        w_step     = w_run_step || w_flush_step;
        w_new_tag  = w_run_step;
        w_in_xfer  = (r_state == LOAD) && in_valid;
        w_last_in  = w_in_xfer && (r_in_cnt == IN_LAST);
        w_last_w   = w_run_step && (r_w_cnt == (r_num_weights - CNT_ONE));
        w_start_ok = (r_state == IDLE) && start;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (w_last_in) begin
                    if (r_num_weights != {CNT_WIDTH{1'b0}}) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            RUN: begin
                if (w_last_w) begin
                    w_state_nxt = FLUSH;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (w_tags_empty && !r_out_valid) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = FLUSH;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job length latch and input/weight counters; cleared on every accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_weights <= {CNT_WIDTH{1'b0}};
            r_in_cnt      <= {IN_CNT_W{1'b0}};
            r_w_cnt       <= {CNT_WIDTH{1'b0}};
        end else if (w_start_ok) begin
            r_num_weights <= num_weights;
            r_in_cnt      <= {IN_CNT_W{1'b0}};
            r_w_cnt       <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_in_xfer) begin
                r_in_cnt <= r_in_cnt + IN_ONE;
            end else begin
                r_in_cnt <= r_in_cnt;
            end
            if (w_run_step) begin
                r_w_cnt <= r_w_cnt + CNT_ONE;
            end else begin
                r_w_cnt <= r_w_cnt;
            end
        end
    end

    // Tag pipeline mirrors the array depth: a 1 marks a step that carried a
    // real weight; it reaches the tail exactly when that psum is on array_psum_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tags <= {PIPE_LATENCY{1'b0}};
        end else if (w_start_ok) begin
            r_tags <= {PIPE_LATENCY{1'b0}};
        end else if (w_step) begin
            r_tags <= {r_tags[PIPE_LATENCY-2:0], w_new_tag};
        end else begin
            r_tags <= r_tags;
        end
    end

    // Result register: capture a tagged psum on a step, release on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {(ARRAY_HEIGHT*PSUM_WIDTH){1'b0}};
        end else if (w_step && w_tail) begin
            r_out_valid <= 1'b1;
            r_out_data  <= array_psum_in;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
        end
    end

    // Output decode; all derive from registered state so reset forces them low
    always_comb begin
        busy             = (r_state != IDLE);
        done             = (r_state == DONE);
        in_ready         = (r_state == LOAD);
        array_input_en   = w_in_xfer;
        if (r_state == LOAD) begin
            array_input_in = in_data;
        end else begin
            array_input_in = {(ARRAY_HEIGHT*INPUT_WIDTH){1'b0}};
        end
        w_ready          = w_run_step;
        array_process_en = w_step;
        if (w_run_step) begin
            array_weight_in = w_data;
        end else begin
            array_weight_in = {(ARRAY_WIDTH*WEIGHT_WIDTH){1'b0}};
        end
        out_valid        = r_out_valid;
        out_data         = r_out_data;
    end

endmodule

// File: tb/tb_is_array_sequencer.sv
// -----------------------------------------------------------------------------
// tb_is_array_sequencer
// Directed bench: a behavioural array (PIPE_LATENCY-step delay line whose psum
// is a fixed repacking of the weight vector) feeds the sequencer; each job is
// driven cycle by cycle and its results, step counts and handshake rules are
// compared against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_is_array_sequencer;

    localparam int IW = 16;
    localparam int WW = 16;
    localparam int PW = 32;
    localparam int AH = 4;
    localparam int AW = 4;
    localparam int PL = 8;
    localparam int CW = 8;

    logic                clk;
    logic                rst;
    logic                start;
    logic [CW-1:0]       num_weights;
    logic                busy;
    logic                done;
    logic                in_valid;
    logic                in_ready;
    logic [AH*IW-1:0]    in_data;
    logic                w_valid;
    logic                w_ready;
    logic [AW*WW-1:0]    w_data;
    logic                array_input_en;
    logic [AH*IW-1:0]    array_input_in;
    logic                array_process_en;
    logic [AW*WW-1:0]    array_weight_in;
    logic [AH*PW-1:0]    array_psum_in;
    logic                out_valid;
    logic                out_ready;
    logic [AH*PW-1:0]    out_data;

    int n_checks = 0;
    int n_errors = 0;
    int job_id   = 0;

    is_array_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_weights(num_weights),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .array_input_en(array_input_en), .array_input_in(array_input_in),
        .array_process_en(array_process_en), .array_weight_in(array_weight_in),
        .array_psum_in(array_psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: weight vectors advance one slot per process step
    logic [AW*WW-1:0] tb_line [PL] = '{default: 64'h0};
    always @(posedge clk) begin
        if (array_process_en) begin
            tb_line[0] <= array_weight_in;
            for (int i = 1; i < PL; i++) tb_line[i] <= tb_line[i-1];
        end
    end

    function automatic logic [AH*PW-1:0] psum_of(input logic [AW*WW-1:0] w);
        logic [AH*PW-1:0] p;
        for (int r = 0; r < AH; r++) p[r*PW +: PW] = {w[r*WW +: WW], 16'h5A00 + 16'(r)};
        return p;
    endfunction

    assign array_psum_in = psum_of(tb_line[PL-1]);

    function automatic logic [AW*WW-1:0] wvec(input int job, input int k);
        logic [AW*WW-1:0] v;
        for (int c = 0; c < AW; c++) v[c*WW +: WW] = 16'h1000 + 16'(job * 256) + 16'(k * 16) + 16'(c);
        return v;
    endfunction

    function automatic logic [AH*IW-1:0] ivec(input int job, input int k);
        logic [AH*IW-1:0] v;
        for (int r = 0; r < AH; r++) v[r*IW +: IW] = 16'hA000 + 16'(job * 256) + 16'(k * 16) + 16'(r);
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one job and check its results and handshake behaviour.
    // wpat 0: w_valid always high, 1: w_valid high every other cycle.
    // Cycles [bp_at, bp_at+bp_len) hold out_ready low; restart_at re-pulses start.
    task automatic run_job(input int n, input int wpat, input int bp_at, input int bp_len,
                           input int restart_at);
        int in_idx = 0, w_idx = 0, cyc = 0, post = 0;
        int n_in_en = 0, n_steps = 0, n_run = 0, n_done = 0, n_ov = 0;
        int viol_in = 0, viol_w = 0, viol_freeze = 0, viol_hold = 0;
        logic hold = 1'b0;
        logic [AH*PW-1:0] held = '0;
        logic [AH*PW-1:0] got[$];
        job_id++;
        while (cyc < 400 && post < 3) begin
            @(posedge clk); #1;
            start       = (cyc == 0) || (cyc == restart_at);
            num_weights = (cyc == 0) ? CW'(n) : 8'd7;
            in_valid    = 1'b1;
            in_data     = ivec(job_id, in_idx);
            w_valid     = (wpat == 0) ? 1'b1 : cyc[0];
            w_data      = wvec(job_id, w_idx);
            out_ready   = !(cyc >= bp_at && cyc < bp_at + bp_len);
            @(negedge clk);
            if (in_ready && (array_input_en !== in_valid || array_input_in !== in_data)) viol_in++;
            if (array_input_en) n_in_en++;
            if (in_valid && in_ready) in_idx++;
            if (array_process_en) n_steps++;
            if (w_ready) n_run++;
            if (w_ready && (!w_valid || !array_process_en || array_weight_in !== w_data)) viol_w++;
            if (array_process_en && !w_ready && array_weight_in !== '0) viol_w++;
            if (w_valid && w_ready) w_idx++;
            if (out_valid && !out_ready && array_process_en) viol_freeze++;
            if (hold && (!out_valid || out_data !== held)) viol_hold++;
            hold = out_valid && !out_ready;
            held = out_data;
            if (out_valid) n_ov++;
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) n_done++;
            if (n_done > 0) post++;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b1;
        check_val("done_count", n_done, 1);
        check_val("input_en_pulses", n_in_en, AW);
        check_val("run_steps", n_run, n);
        check_val("flush_steps", n_steps - n_run, (n > 0) ? PL : 0);
        check_val("result_count", got.size(), n);
        for (int i = 0; i < got.size() && i < n; i++)
            check_val($sformatf("result_%0d", i), got[i], psum_of(wvec(job_id, i)));
        check_val("load_path", viol_in, 0);
        check_val("weight_path", viol_w, 0);
        check_val("freeze_on_stall", viol_freeze, 0);
        check_val("out_data_stable", viol_hold, 0);
        if (n == 0) check_val("zero_job_no_out", n_ov, 0);
        check_val("idle_after_job", busy, 0);
    endtask

    initial begin
        int n_run, n_late;
        rst = 1'b1; start = 1'b0; num_weights = '0; in_valid = 1'b0; in_data = '0;
        w_valid = 1'b0; w_data = '0; out_ready = 1'b1;
        #12;
        check_val("rst_outputs", {busy, done, in_ready, w_ready, out_valid,
                                  array_input_en, array_process_en}, 7'b0);
        check_val("rst_weight_in", array_weight_in, 0);
        check_val("rst_out_data", out_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_job(3, 0, 1000, 0, -1);   // basic
        run_job(5, 0, 12, 20, -1);    // output backpressure
        run_job(4, 1, 1000, 0, -1);   // weight starvation
        run_job(0, 0, 1000, 0, -1);   // zero-length job
        run_job(3, 0, 1000, 0, 7);    // start while busy ignored

        // Reset in the middle of RUN
        job_id++;
        @(posedge clk); #1;
        start = 1'b1; num_weights = 8'd5; in_valid = 1'b1; w_valid = 1'b1;
        in_data = ivec(job_id, 0); w_data = wvec(job_id, 0);
        n_run = 0;
        for (int c = 0; c < 40 && n_run < 2; c++) begin
            @(negedge clk);
            if (w_ready) n_run++;
            @(posedge clk); #1 start = 1'b0;
        end
        check_val("rst_reached_run", n_run, 2);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_outputs", {busy, done, in_ready, w_ready, out_valid,
                                     array_input_en, array_process_en}, 7'b0);
        check_val("midrst_weight_in", array_weight_in, 0);
        check_val("midrst_out_data", out_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        n_late = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid || done || busy) n_late++;
        end
        check_val("abandoned_job_silent", n_late, 0);
        in_valid = 1'b0; w_valid = 1'b0;
        run_job(3, 0, 1000, 0, -1);   // clean job after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
